// File: rtl/des_pkg.sv
// des_pkg: shared types and constants for the DES request scheduler.
//   DES_LAT   - default engine latency in clocks
//   REQ_ID_W  - width of a requester id (two requesters)
//   des_blk_t - one 64-bit DES block
//   req_id_t  - requester id
//   des_tag_t - {valid, owner} record tracking one block through the engine
package des_pkg;

    localparam int DES_LAT  = 17;
    localparam int REQ_ID_W = 1;

    typedef logic [63:0]         des_blk_t;
    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t owner;
    } des_tag_t;

endpackage

// File: rtl/des_tag_pipe.sv
// des_tag_pipe: DEPTH-stage shift register of des_tag_t that mirrors the
// engine pipeline, so the tag leaving the last stage belongs to the block
// the engine is presenting at the same time.
//   clk       - clock, rising edge
//   rst_n     - synchronous active-low clear of every stage
//   tag_in    - tag loaded into stage 0 every edge
//   tag_out   - contents of the last stage
//   any_valid - some stage holds a valid tag
module des_tag_pipe
    import des_pkg::*;
#(
    parameter int DEPTH = DES_LAT + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  des_tag_t tag_in,
    output des_tag_t tag_out,
    output logic     any_valid
);

    des_tag_t stage [DEPTH];

    // NOTE: every stage is cleared, not just the valid bits, because reset
    // must drop all in-flight blocks and an uncleared register array would
    // carry X owners into the response logic after power-up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage take its
            // predecessor's old value, giving a true shift regardless of
            // loop order.
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // NOTE: the default before the loop keeps this combinational block
    // from inferring a latch.
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage[i].valid;
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/des_req_sched.sv
// des_req_sched: round-robin scheduler that lets two requesters share one
// fixed-latency, non-stallable des_enc pipeline and routes each ciphertext
// back to the requester that supplied the plaintext.
//   clk, rst_n               - clock and synchronous active-low reset
//   req0_valid/data/ready    - requester 0 plaintext handshake
//   req1_valid/data/ready    - requester 1 plaintext handshake
//   eng_in                   - registered plaintext to des_enc (0 when idle)
//   eng_out                  - ciphertext from des_enc, LAT clocks later
//   rsp0_valid/data          - one-cycle result pulse for requester 0
//   rsp1_valid/data          - one-cycle result pulse for requester 1
//   idle                     - nothing in flight and no pulse pending
//   done_cnt0/1              - saturating completed-response counters
module des_req_sched
    import des_pkg::*;
#(
    parameter int LAT   = DES_LAT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  des_blk_t         req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  des_blk_t         req1_data,
    output logic             req1_ready,
    output des_blk_t         eng_in,
    input  des_blk_t         eng_out,
    output logic             rsp0_valid,
    output des_blk_t         rsp0_data,
    output logic             rsp1_valid,
    output des_blk_t         rsp1_data,
    output logic             idle,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    req_id_t  last_id;      // requester granted on the most recent transfer
    logic     transfer;
    req_id_t  gnt_id;
    des_blk_t gnt_data;
    des_tag_t tag_in;
    des_tag_t tag_out;
    logic     tags_busy;
    logic     hit0;
    logic     hit1;

    // Ready depends only on the valids and the pointer, never on ready of
    // the other port, so there is no combinational loop through requesters.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                // Contention: whoever was not granted last goes now.
                req0_ready = (last_id == 1'b1);
                req1_ready = (last_id == 1'b0);
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign transfer = req0_ready | req1_ready;
    assign gnt_id   = req1_ready;
    assign gnt_data = req1_ready ? req1_data : req0_data;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = transfer;
        tag_in.owner = gnt_id;
    end

    // Depth LAT+1: one stage covers the eng_in register, LAT cover the engine.
    des_tag_pipe #(
        .DEPTH (LAT + 1)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (tags_busy)
    );

    assign hit0 = tag_out.valid && (tag_out.owner == 1'b0);
    assign hit1 = tag_out.valid && (tag_out.owner == 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eng_in     <= '0;
            last_id    <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
            done_cnt0  <= '0;
            done_cnt1  <= '0;
        end else begin
            // Idle cycles feed zeros so the engine never sees stale data.
            eng_in <= transfer ? gnt_data : '0;
            if (transfer) begin
                last_id <= gnt_id;
            end
            rsp0_valid <= hit0;
            rsp1_valid <= hit1;
            if (hit0) begin
                rsp0_data <= eng_out;
                if (done_cnt0 != CNT_MAX) begin
                    done_cnt0 <= done_cnt0 + 1'b1;
                end
            end
            if (hit1) begin
                rsp1_data <= eng_out;
                if (done_cnt1 != CNT_MAX) begin
                    done_cnt1 <= done_cnt1 + 1'b1;
                end
            end
        end
    end

    assign idle = !tags_busy && !rsp0_valid && !rsp1_valid;

endmodule
